// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the integer register file.
// Default XLEN/NREGS are also used by decode and writeback.
package regfile_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;
  localparam int X0        = 0;

  function automatic int calcAw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy bits for in-flight destinations, issue gating.
// REGFILE_BYPASS_EN masks rbusy when the same register retires this cycle.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = calcAw(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issValid,
  input  logic [AW-1:0]     issRd,
  input  logic [NREGS-1:0]  wrMask,
  input  logic [NRD*AW-1:0] raddr,
  output logic              issReady,
  output logic [NRD-1:0]    rbusy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] setMask;
  logic             issFire;

  // Issue is blocked only by a busy, non-retiring destination
  always_comb begin
    issReady = rst && ((issRd == AW'(X0)) || !busy[issRd] || wrMask[issRd]);
    issFire  = issValid && issReady;
    setMask  = '0;
    if (issFire && (issRd != AW'(X0)))
      setMask[issRd] = 1'b1;
  end

  // Set wins over clear so the newest producer owns the register
  always_ff @(posedge clk) begin
    if (!rst)
      busy <= '0;
    else
      busy <= (busy & ~wrMask) | setMask;
  end

  // Per-read-port busy lookup
  always_comb begin
    rbusy = '0;
    for (int k = 0; k < NRD; k++) begin
`ifdef REGFILE_BYPASS_EN
      rbusy[k] = rst && busy[raddr[k*AW +: AW]]
                 && !wrMask[raddr[k*AW +: AW]];
`else
      rbusy[k] = rst && busy[raddr[k*AW +: AW]];
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  parameter int AW    = calcAw(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ready
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] wrMask;

  // One-hot set of registers retiring this cycle (x0 excluded)
  always_comb begin
    wrMask = '0;
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && (waddr[j*AW +: AW] != AW'(X0)))
        wrMask[waddr[j*AW +: AW]] = 1'b1;
    end
  end

  // Storage update; later ports override earlier ones
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (waddr[j*AW +: AW] != AW'(X0)))
          regs[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
      end
    end
  end

  // Read muxing with optional forwarding from the write ports
  always_comb begin
    rdata = '0;
    for (int k = 0; k < NRD; k++) begin
      if (rst && (raddr[k*AW +: AW] != AW'(X0))) begin
        rdata[k*XLEN +: XLEN] = regs[raddr[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++) begin
          if (we[j] && (waddr[j*AW +: AW] == raddr[k*AW +: AW]))
            rdata[k*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
        end
`endif
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) uSb (
    .clk      (clk),
    .rst      (rst),
    .issValid (iss_valid),
    .issRd    (iss_rd),
    .wrMask   (wrMask),
    .raddr    (raddr),
    .issReady (iss_ready),
    .rbusy    (rbusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks for regfile_mp (NRD=2, NWR=2).
// Bypass expectations follow REGFILE_BYPASS_EN.
module tb_regfile_mp;

  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [2*AW-1:0] raddr;
  logic [2*XLEN-1:0] rdata;
  logic [1:0]      rbusy;
  logic [1:0]      we;
  logic [2*AW-1:0] waddr;
  logic [2*XLEN-1:0] wdata;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            iss_ready;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN  (64),
    .NREGS (32),
    .NRD   (2),
    .NWR   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we        = 2'b00;
    waddr     = '0;
    wdata     = '0;
    iss_valid = 1'b0;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we[0]          = 1'b1;
    waddr[0 +: AW] = a;
    wdata[0 +: XLEN] = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    raddr = {5'd6, 5'd5};
    iss_rd = 5'd5;
    tick();
    tick();
    nChecks++;
    if (iss_ready !== 1'b0) begin
      nFails++;
      $display("FAIL rst_ready got %b want 0", iss_ready);
    end
    nChecks++;
    if (rbusy !== 2'b00) begin
      nFails++;
      $display("FAIL rst_rbusy got %b want 00", rbusy);
    end
    rst = 1'b1;
    wr0(5'd5, 64'hAA);
    tick();
    idle();
    #1;
    nChecks++;
    if (rdata[0 +: XLEN] !== 64'hAA) begin
      nFails++;
      $display("FAIL pre_rst_x5 got %h want aa", rdata[0 +: XLEN]);
    end
    iss_valid = 1'b1;
    iss_rd    = 5'd6;
    tick();
    idle();
    #1;
    nChecks++;
    if (rbusy[1] !== 1'b1) begin
      nFails++;
      $display("FAIL pre_rst_busy6 got %b want 1", rbusy[1]);
    end
    rst = 1'b0;
    wr0(5'd5, 64'hBB);
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    #1;
    nChecks++;
    if (iss_ready !== 1'b0 || rbusy !== 2'b00 || rdata !== '0) begin
      nFails++;
      $display("FAIL in_rst_outs got rdy=%b busy=%b data=%h want 0 0 0",
               iss_ready, rbusy, rdata);
    end
    tick();
    rst = 1'b1;
    idle();
    raddr = {5'd7, 5'd5};
    #1;
    nChecks++;
    if (rdata[0 +: XLEN] !== 64'h0) begin
      nFails++;
      $display("FAIL post_rst_x5 got %h want 0", rdata[0 +: XLEN]);
    end
    nChecks++;
    if (rbusy !== 2'b00) begin
      nFails++;
      $display("FAIL post_rst_busy got %b want 00", rbusy);
    end
    raddr = {5'd6, 5'd5};
    #1;
    nChecks++;
    if (rbusy[1] !== 1'b0) begin
      nFails++;
      $display("FAIL post_rst_busy6 got %b want 0", rbusy[1]);
    end
  endtask

  task automatic test_x0();
    idle();
    wr0(5'd0, 64'hFFFF);
    raddr = {5'd0, 5'd0};
    tick();
    idle();
    #1;
    nChecks++;
    if (rdata !== '0) begin
      nFails++;
      $display("FAIL x0_read got %h want 0", rdata);
    end
    iss_valid = 1'b1;
    iss_rd    = 5'd0;
    #1;
    nChecks++;
    if (iss_ready !== 1'b1) begin
      nFails++;
      $display("FAIL x0_issue_ready got %b want 1", iss_ready);
    end
    tick();
    idle();
    #1;
    nChecks++;
    if (rbusy !== 2'b00) begin
      nFails++;
      $display("FAIL x0_busy got %b want 00", rbusy);
    end
  endtask

  task automatic test_scoreboard();
    logic expBusy;
    idle();
    raddr = {5'd8, 5'd7};
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    #1;
    nChecks++;
    if (iss_ready !== 1'b1) begin
      nFails++;
      $display("FAIL sb_first_ready got %b want 1", iss_ready);
    end
    tick();
    #1;
    nChecks++;
    if (rbusy !== 2'b01 || iss_ready !== 1'b0) begin
      nFails++;
      $display("FAIL sb_waw_stall got busy=%b rdy=%b want 01 0",
               rbusy, iss_ready);
    end
    tick();
    idle();
    #1;
    nChecks++;
    if (rbusy[0] !== 1'b1) begin
      nFails++;
      $display("FAIL sb_idle2 got %b want 1", rbusy[0]);
    end
    wr0(5'd7, 64'h12);
`ifdef REGFILE_BYPASS_EN
    expBusy = 1'b0;
`else
    expBusy = 1'b1;
`endif
    #1;
    nChecks++;
    if (rbusy[0] !== expBusy || iss_ready !== 1'b1) begin
      nFails++;
      $display("FAIL sb_wb_cycle got busy=%b rdy=%b want %b 1",
               rbusy[0], iss_ready, expBusy);
    end
    tick();
    idle();
    #1;
    nChecks++;
    if (rbusy[0] !== 1'b0 || rdata[0 +: XLEN] !== 64'h12) begin
      nFails++;
      $display("FAIL sb_after_wb got busy=%b data=%h want 0 12",
               rbusy[0], rdata[0 +: XLEN]);
    end
  endtask

  task automatic test_collision();
    idle();
    raddr = {5'd0, 5'd9};
    iss_valid = 1'b1;
    iss_rd    = 5'd9;
    wr0(5'd9, 64'h99);
    tick();
    idle();
    #1;
    nChecks++;
    if (rbusy[0] !== 1'b1 || rdata[0 +: XLEN] !== 64'h99) begin
      nFails++;
      $display("FAIL collision got busy=%b data=%h want 1 99",
               rbusy[0], rdata[0 +: XLEN]);
    end
    wr0(5'd9, 64'h9A);
    tick();
    idle();
    #1;
    nChecks++;
    if (rbusy[0] !== 1'b0 || rdata[0 +: XLEN] !== 64'h9A) begin
      nFails++;
      $display("FAIL collision_retire got busy=%b data=%h want 0 9a",
               rbusy[0], rdata[0 +: XLEN]);
    end
  endtask

  task automatic test_dual_write();
    logic [XLEN-1:0] expNow;
    idle();
    raddr = {5'd3, 5'd3};
    we    = 2'b11;
    waddr = {5'd3, 5'd3};
    wdata = {64'h2, 64'h1};
`ifdef REGFILE_BYPASS_EN
    expNow = 64'h2;
`else
    expNow = 64'h0;
`endif
    #1;
    nChecks++;
    if (rdata[XLEN +: XLEN] !== expNow) begin
      nFails++;
      $display("FAIL dual_same_cycle got %h want %h",
               rdata[XLEN +: XLEN], expNow);
    end
    tick();
    idle();
    #1;
    nChecks++;
    if (rdata[0 +: XLEN] !== 64'h2 || rdata[XLEN +: XLEN] !== 64'h2) begin
      nFails++;
      $display("FAIL dual_write got %h want 2/2", rdata);
    end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] expNow;
    idle();
    raddr = {5'd4, 5'd4};
    wr0(5'd4, 64'h11);
    tick();
    idle();
    wr0(5'd4, 64'h55);
`ifdef REGFILE_BYPASS_EN
    expNow = 64'h55;
`else
    expNow = 64'h11;
`endif
    #1;
    nChecks++;
    if (rdata[0 +: XLEN] !== expNow || rdata[XLEN +: XLEN] !== expNow) begin
      nFails++;
      $display("FAIL bypass_same_cycle got %h want %h on both ports",
               rdata, expNow);
    end
    tick();
    idle();
    #1;
    nChecks++;
    if (rdata[0 +: XLEN] !== 64'h55) begin
      nFails++;
      $display("FAIL bypass_next_cycle got %h want 55", rdata[0 +: XLEN]);
    end
  endtask

  initial begin
    test_reset();
    test_x0();
    test_scoreboard();
    test_collision();
    test_dual_write();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with an integrated busy-bit scoreboard, for the pipelined RISC-V core. It provides NRD combinational read ports and NWR write-back ports, and hardwires x0 to zero. It tracks in-flight destination registers so decode can detect RAW and WAW hazards. An optional same-cycle write-to-read bypass is compiled in by macro.

## Interface
Parameters:
- XLEN, 64, data width per register
- NREGS, 32, register count (power of two, ≥2); AW = clog2(NREGS)
- NRD, 2, read port count (1..4)
- NWR, 1, write-back port count (1..2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- raddr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
- rdata  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
- rbusy  out  NRD  busy flag of the register addressed by port k
- we  in  NWR  write enable per write-back port
- waddr  in  NWR*AW  write addresses
- wdata  in  NWR*XLEN  write data
- iss_valid  in  1  decode requests to issue an instruction writing iss_rd
- iss_rd  in  AW  destination of the issuing instruction
- iss_ready  out  1  issue accepted this cycle (handshake iss_valid && iss_ready)

## Operation
- Storage: NREGS x XLEN flops. x0 is never written, never busy, and always reads 0.
- Reset: on a clk edge with rst==0, all registers clear to 0 and all busy bits clear. While rst==0: rdata=0, rbusy=0, iss_ready=0. Reset mid-operation discards pending scoreboard entries. Writes and issues in that cycle are ignored.
- Write: on each edge with rst==1, every port j with we[j] && waddr_j!=0 writes wdata_j.
  - Two ports write the same address: port NWR-1 (highest index) wins.
- Read: rdata_k = regs[raddr_k], or 0 if raddr_k==0. Combinational.
- Scoreboard: busy[r] is set on an accepted issue to r (r≠0). It is cleared when any write port writes r.
  - Accepted issue and write-back to the same r in one cycle: busy ends set, because the new producer wins.
  - Issue of iss_rd==0: accepted, with no busy change.
- iss_ready = rst && (iss_rd==0 || !busy[iss_rd] || write-back to iss_rd this cycle). This stalls WAW until the older producer retires.
- rbusy_k = busy[raddr_k] && !(write to raddr_k this cycle when bypass is enabled).

## Timing
- Read latency: 0 cycles (combinational from raddr).
- Write visible on rdata: the cycle after the write edge. With the bypass enabled, it is visible in the same cycle.
- Busy set visible the cycle after issue acceptance. Clear is visible the cycle after write-back, or the same cycle through rbusy/iss_ready as defined above.
- Address wrap: waddr/raddr are AW bits wide, so no out-of-range index exists when NREGS = 2^AW.
- rdata, rbusy, and iss_ready have no registered output stage.

## Configuration
- REGFILE_BYPASS_EN defined: a read port whose address matches an enabled non-zero write port in the same cycle returns that port's wdata, using the highest-index port on conflict. rbusy is masked accordingly.
- REGFILE_BYPASS_EN undefined: reads return only stored contents. The same-cycle write is visible next cycle, and rbusy reflects stored busy only. iss_ready is unaffected by the macro.

## Structure
- Package regfile_pkg holds:
  - the X0 address constant (0)
  - the AW derivation function (clog2)
  - the default XLEN/NREGS constants shared with decode and writeback
- Sub-module regfile_scoreboard holds:
  - the NREGS busy vector
  - the set/clear priority logic
  - the iss_ready and per-port busy lookups
- The top level holds storage, write arbitration, and the read/bypass muxing.

## Test plan
- Reset: write x5=0xAA, then hold rst=0 for one edge. Result: x5 reads 0, all rbusy=0, and iss_ready=0 during reset.
- x0: we=1, waddr=0, wdata=0xFFFF. Result: x0 reads 0, and issue to x0 leaves rbusy=0.
- Scoreboard: issue x7, then two idle cycles, then write-back x7=0x12. Result: rbusy(x7)=1 for those cycles and 0 after write-back. A second issue to x7 while busy sees iss_ready=0.
- Collision: in the same cycle, accept an issue to x9 and write back x9. Result: x9 stays busy next cycle, and data equals the written value.
- Dual write (NWR=2): both ports write x3, with 0x1 on port 0 and 0x2 on port 1. Result: x3 reads 0x2.
- Bypass: write x4=0x55 while reading x4 in the same cycle. Result: rdata=0x55 with REGFILE_BYPASS_EN, and the old value without it.
